// File: rtl/pistorm_bus_pkg.sv
// Shared types and constants for the PiStorm16 68000 bus interface.
package pistorm_bus_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 23;

  typedef enum logic [3:0] {
    IDLE, S0, S1, S2, S3, S4, S5, S6, S7
  } bus_state_t;

  // 68000 function codes
  localparam logic [2:0] FC_USER_DATA  = 3'd1;
  localparam logic [2:0] FC_USER_PROG  = 3'd2;
  localparam logic [2:0] FC_SUPER_DATA = 3'd5;
  localparam logic [2:0] FC_SUPER_PROG = 3'd6;
  localparam logic [2:0] FC_CPU_SPACE  = 3'd7;

endpackage

// File: rtl/m68k_wait_counter.sv
// Saturating 8-bit wait-state counter with a terminal flag against TIMEOUT_WAITS.
module m68k_wait_counter #(
  parameter int TIMEOUT_WAITS = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // High when the next counted wait edge reaches the limit.
  assign expire_o = ({1'b0, count_q} + 9'd1) >= 9'(TIMEOUT_WAITS);

endmodule

// File: rtl/m68k_bus_sequencer.sv
// One 68000 read/write bus cycle per host request, stepped through S0..S7 by MCCLK strobes.
module m68k_bus_sequencer #(
  parameter int TIMEOUT_WAITS = 255,
  parameter int ADDR_W        = 23
) (
  input  logic                                SYSCLK,
  input  logic                                RESET,
  input  logic                                MCCLK_RISING,
  input  logic                                MCCLK_FALLING,
  input  logic                                DTACK_LATCH,
  input  logic                                REQ,
  input  logic                                REQ_WRITE,
  input  logic [ADDR_W-1:0]                   REQ_ADDR,
  input  logic                                REQ_UDS,
  input  logic                                REQ_LDS,
  input  logic [2:0]                          REQ_FC,
  input  logic [pistorm_bus_pkg::DATA_W-1:0]  REQ_WDATA,
  input  logic [pistorm_bus_pkg::DATA_W-1:0]  DATA_IN,
  output logic                                ACK,
  output logic                                ERR,
  output logic [pistorm_bus_pkg::DATA_W-1:0]  RDATA,
  output logic                                BUSY,
  output logic                                AS_N,
  output logic                                UDS_N,
  output logic                                LDS_N,
  output logic                                RW,
  output logic [ADDR_W-1:0]                   ADDR,
  output logic [2:0]                          FC,
  output logic [pistorm_bus_pkg::DATA_W-1:0] DATA_OUT,
  output logic                                DATA_OE
);

  import pistorm_bus_pkg::*;

  bus_state_t          state_q;
  logic                write_q, uds_q, lds_q, abort_q;
  logic [ADDR_W-1:0]   addr_q, addr_out_q;
  logic [2:0]          fc_q, fc_out_q;
  logic [DATA_W-1:0]   wdata_q, dout_q, rdata_q;
  logic                as_n_q, uds_n_q, lds_n_q, rw_q, oe_q, ack_q, err_q, busy_q;
  logic                rise, fall, wc_clr, wc_en, wc_expire;

  // Both strobes together can only be a synchronizer fault; treat as no edge.
  assign rise   = MCCLK_RISING & ~MCCLK_FALLING;
  assign fall   = MCCLK_FALLING & ~MCCLK_RISING;
  assign wc_clr = (state_q == S3) && rise;
  assign wc_en  = (state_q == S4) && fall && !DTACK_LATCH;

  m68k_wait_counter #(.TIMEOUT_WAITS(TIMEOUT_WAITS)) u_wait (
    .clk_i    (SYSCLK),
    .rst_i    (RESET),
    .clr_i    (wc_clr),
    .en_i     (wc_en),
    .expire_o (wc_expire)
  );

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      uds_q      <= 1'b0;
      lds_q      <= 1'b0;
      abort_q    <= 1'b0;
      addr_q     <= '0;
      addr_out_q <= '0;
      fc_q       <= '0;
      fc_out_q   <= '0;
      wdata_q    <= '0;
      dout_q     <= '0;
      rdata_q    <= '0;
      as_n_q     <= 1'b1;
      uds_n_q    <= 1'b1;
      lds_n_q    <= 1'b1;
      rw_q       <= 1'b1;
      oe_q       <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: if (rise && REQ) begin
          state_q <= S0;
          busy_q  <= 1'b1;
          write_q <= REQ_WRITE;
          uds_q   <= REQ_UDS;
          lds_q   <= REQ_LDS;
          addr_q  <= REQ_ADDR;
          fc_q    <= REQ_FC;
          wdata_q <= REQ_WDATA;
          rw_q    <= ~REQ_WRITE;
        end
        S0: if (fall) begin
          state_q    <= S1;
          addr_out_q <= addr_q;
          fc_out_q   <= fc_q;
        end
        S1: if (rise) begin
          state_q <= S2;
          as_n_q  <= 1'b0;
          if (!write_q) begin
            uds_n_q <= ~uds_q;
            lds_n_q <= ~lds_q;
          end
        end
        S2: if (fall) begin
          state_q <= S3;
          if (write_q) begin
            dout_q <= wdata_q;
            oe_q   <= 1'b1;
          end
        end
        S3: if (rise) begin
          state_q <= S4;
          if (write_q) begin
            uds_n_q <= ~uds_q;
            lds_n_q <= ~lds_q;
          end
        end
        S4: if (fall) begin
          if (DTACK_LATCH) begin
            state_q <= S5;
          end else if (wc_expire) begin
            // Timeout: jump straight to S7 with the strobes released.
            state_q <= S7;
            abort_q <= 1'b1;
            as_n_q  <= 1'b1;
            uds_n_q <= 1'b1;
            lds_n_q <= 1'b1;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        S5: if (rise) begin
          state_q <= S6;
        end
        S6: if (fall) begin
          state_q <= S7;
          if (!write_q) begin
            rdata_q <= DATA_IN;
          end
          as_n_q  <= 1'b1;
          uds_n_q <= 1'b1;
          lds_n_q <= 1'b1;
          ack_q   <= 1'b1;
          err_q   <= abort_q;
        end
        S7: if (rise) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          oe_q    <= 1'b0;
          rw_q    <= 1'b1;
          abort_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ACK      = ack_q;
  assign ERR      = err_q;
  assign RDATA    = rdata_q;
  assign BUSY     = busy_q;
  assign AS_N     = as_n_q;
  assign UDS_N    = uds_n_q;
  assign LDS_N    = lds_n_q;
  assign RW       = rw_q;
  assign ADDR     = addr_out_q;
  assign FC       = fc_out_q;
  assign DATA_OUT = dout_q;
  assign DATA_OE  = oe_q;

endmodule

// File: tb/tb_m68k_bus_sequencer.sv
// Directed bench for m68k_bus_sequencer: MCCLK strobe generator, DTACK responder, checked cycles.
module tb_m68k_bus_sequencer;
  import pistorm_bus_pkg::*;

  logic        SYSCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        MCCLK_RISING = 1'b0, MCCLK_FALLING = 1'b0, DTACK_LATCH = 1'b0;
  logic        REQ = 1'b0, REQ_WRITE = 1'b0, REQ_UDS = 1'b0, REQ_LDS = 1'b0;
  logic [22:0] REQ_ADDR = '0;
  logic [2:0]  REQ_FC = '0;
  logic [15:0] REQ_WDATA = '0, DATA_IN = '0;
  logic        ACK, ERR, BUSY, AS_N, UDS_N, LDS_N, RW, DATA_OE;
  logic [15:0] RDATA, DATA_OUT;
  logic [22:0] ADDR;
  logic [2:0]  FC;

  int n_cmp = 0, n_bad = 0, ack_seen = 0;
  int phase = 0, fall_cnt = 0, dtack_delay = 0;
  bit inject_both = 1'b0;

  m68k_bus_sequencer #(.TIMEOUT_WAITS(4), .ADDR_W(23)) dut (
    .SYSCLK(SYSCLK), .RESET(RESET), .MCCLK_RISING(MCCLK_RISING), .MCCLK_FALLING(MCCLK_FALLING),
    .DTACK_LATCH(DTACK_LATCH), .REQ(REQ), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR),
    .REQ_UDS(REQ_UDS), .REQ_LDS(REQ_LDS), .REQ_FC(REQ_FC), .REQ_WDATA(REQ_WDATA),
    .DATA_IN(DATA_IN), .ACK(ACK), .ERR(ERR), .RDATA(RDATA), .BUSY(BUSY), .AS_N(AS_N),
    .UDS_N(UDS_N), .LDS_N(LDS_N), .RW(RW), .ADDR(ADDR), .FC(FC), .DATA_OUT(DATA_OUT),
    .DATA_OE(DATA_OE)
  );

  always #5 SYSCLK = ~SYSCLK;

  // MCCLK = 8 SYSCLK: rising strobe at phase 0, falling at phase 4.
  // DTACK rises once dtack_delay S4 falling edges have passed (-1 = never).
  initial forever begin
    @(negedge SYSCLK);
    if (inject_both) begin
      MCCLK_RISING  = 1'b1;
      MCCLK_FALLING = 1'b1;
      inject_both   = 1'b0;
    end else begin
      MCCLK_RISING  = (phase == 0);
      MCCLK_FALLING = (phase == 4);
      phase = (phase + 1) % 8;
    end
    if (AS_N) begin
      fall_cnt    = 0;
      DTACK_LATCH = 1'b0;
    end else if (MCCLK_FALLING && !MCCLK_RISING) begin
      fall_cnt++;
      DTACK_LATCH = (dtack_delay >= 0) && (fall_cnt >= dtack_delay + 2);
    end
  end

  initial forever begin
    @(negedge SYSCLK);
    if (ACK === 1'b1) ack_seen++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic wait_edge(input bit rising, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      if (rising) hit = MCCLK_RISING && !MCCLK_FALLING;
      else        hit = MCCLK_FALLING && !MCCLK_RISING;
    end
    chk({tag, "_edge"}, 32'(hit), 32'd1);
  endtask

  task automatic set_req(input bit wr, input logic [22:0] addr, input logic uds, input logic lds,
                         input logic [2:0] fc, input logic [15:0] wd, input int dly);
    REQ_WRITE = wr; REQ_ADDR = addr; REQ_UDS = uds; REQ_LDS = lds;
    REQ_FC = fc; REQ_WDATA = wd; dtack_delay = dly;
    REQ = 1'b1;
  endtask

  // Runs until the sequencer is back in IDLE; counts MCCLK periods while busy.
  task automatic run_cycle(input string tag, input bit keep, output int periods, output int acks,
                           output int aslow, output logic err, output logic [15:0] rd,
                           output logic [2:0] strb);
    bit started = 1'b0, done = 1'b0;
    periods = 0; acks = 0; aslow = 0; err = 1'b0; rd = '0; strb = '0;
    for (int i = 0; i < 600 && !done; i++) begin
      tick();
      if (BUSY) started = 1'b1;
      if (MCCLK_RISING && !MCCLK_FALLING) begin
        if (BUSY) begin
          periods++;
          if (!AS_N) aslow++;
        end else if (started) begin
          done = 1'b1;
        end
      end
      if (ACK) begin
        acks++; err = ERR; rd = RDATA; strb = {AS_N, UDS_N, LDS_N};
        if (!keep) REQ = 1'b0;
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  int periods, acks, aslow, ack_before;
  logic err;
  logic [15:0] rd;
  logic [2:0] strb;

  initial begin
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    chk("rst_strobes_rw", {AS_N, UDS_N, LDS_N, RW}, 4'hF);
    chk("rst_busy_ack_err_oe", {BUSY, ACK, ERR, DATA_OE}, 4'h0);
    chk("rst_addr_fc", {ADDR, FC}, 26'h0);
    chk("rst_dout_rdata", {DATA_OUT, RDATA}, 32'h0);

    // Simultaneous strobes must not start a cycle, then a zero-wait read.
    DATA_IN = 16'hBEEF;
    set_req(1'b0, 23'h000800, 1'b1, 1'b1, FC_SUPER_DATA, 16'h0, 0);
    inject_both = 1'b1;
    tick();
    chk("both_strobes_ignored", BUSY, 1'b0);
    run_cycle("rd0", 1'b0, periods, acks, aslow, err, rd, strb);
    chk("rd0_periods", periods, 4);
    chk("rd0_as_low_periods", aslow, 3);
    chk("rd0_acks", acks, 1);
    chk("rd0_err", err, 1'b0);
    chk("rd0_rdata", rd, 16'hBEEF);
    chk("rd0_strobes_at_ack", strb, 3'b111);
    chk("rd0_addr_fc", {ADDR, FC}, {23'h000800, FC_SUPER_DATA});

    // Lower-byte write, stepped state by state.
    set_req(1'b1, 23'h123456, 1'b0, 1'b1, FC_USER_DATA, 16'h12A5, 0);
    wait_edge(1'b1, "w_s0");
    chk("w_s0_rw_busy", {RW, BUSY}, 2'b01);
    wait_edge(1'b0, "w_s1");
    chk("w_s1_addr_fc", {ADDR, FC}, {23'h123456, FC_USER_DATA});
    wait_edge(1'b1, "w_s2");
    chk("w_s2_as_uds_lds", {AS_N, UDS_N, LDS_N}, 3'b011);
    chk("w_s2_oe", DATA_OE, 1'b0);
    wait_edge(1'b0, "w_s3");
    chk("w_s3_oe_dout", {DATA_OE, DATA_OUT}, {1'b1, 16'h12A5});
    chk("w_s3_lds", LDS_N, 1'b1);
    wait_edge(1'b1, "w_s4");
    chk("w_s4_as_uds_lds", {AS_N, UDS_N, LDS_N}, 3'b010);
    wait_edge(1'b0, "w_s5");
    wait_edge(1'b1, "w_s6");
    wait_edge(1'b0, "w_s7");
    chk("w_s7_ack_err", {ACK, ERR}, 2'b10);
    chk("w_s7_strobes_oe", {AS_N, UDS_N, LDS_N, DATA_OE}, 4'b1111);
    REQ = 1'b0;
    wait_edge(1'b1, "w_idle");
    chk("w_idle_oe_rw_busy", {DATA_OE, RW, BUSY}, 3'b010);

    // Three wait states.
    DATA_IN = 16'h5A5A;
    set_req(1'b0, 23'h000A00, 1'b1, 1'b1, FC_USER_DATA, 16'h0, 3);
    run_cycle("ws3", 1'b0, periods, acks, aslow, err, rd, strb);
    chk("ws3_periods", periods, 7);
    chk("ws3_as_low_periods", aslow, 6);
    chk("ws3_acks_err", {acks[3:0], 3'b000, err}, {4'd1, 4'b0000});
    chk("ws3_rdata", rd, 16'h5A5A);

    // Timeout after four wait edges; RDATA keeps the last read.
    DATA_IN = 16'hAAAA;
    set_req(1'b0, 23'h000C00, 1'b1, 1'b0, FC_USER_DATA, 16'h0, -1);
    run_cycle("tmo", 1'b0, periods, acks, aslow, err, rd, strb);
    chk("tmo_periods", periods, 6);
    chk("tmo_as_low_periods", aslow, 5);
    chk("tmo_acks", acks, 1);
    chk("tmo_err", err, 1'b1);
    chk("tmo_rdata_kept", rd, 16'h5A5A);
    chk("tmo_strobes_at_ack", strb, 3'b111);

    // Reset while in S4 of a read.
    DATA_IN = 16'h7777;
    set_req(1'b0, 23'h000E00, 1'b1, 1'b1, FC_SUPER_DATA, 16'h0, -1);
    wait_edge(1'b1, "rs_accept");
    wait_edge(1'b1, "rs_s2");
    wait_edge(1'b1, "rs_s4");
    chk("rs_s4_as", AS_N, 1'b0);
    tick(); tick();
    ack_before = ack_seen;
    RESET = 1'b1;
    REQ = 1'b0;
    tick();
    RESET = 1'b0;
    chk("rs_strobes", {AS_N, UDS_N, LDS_N}, 3'b111);
    chk("rs_busy_oe", {BUSY, DATA_OE}, 2'b00);
    repeat (40) tick();
    chk("rs_no_ack", ack_seen, ack_before);
    DATA_IN = 16'h1357;
    set_req(1'b0, 23'h000800, 1'b1, 1'b1, FC_SUPER_DATA, 16'h0, 0);
    run_cycle("rs_new", 1'b0, periods, acks, aslow, err, rd, strb);
    chk("rs_new_periods", periods, 4);
    chk("rs_new_acks", acks, 1);
    chk("rs_new_rdata_err", {rd, 15'h0, err}, {16'h1357, 16'h0});

    // Back-to-back with REQ held high.
    DATA_IN = 16'h2468;
    set_req(1'b0, 23'h001000, 1'b1, 1'b1, FC_USER_PROG, 16'h0, 0);
    run_cycle("b2b1", 1'b1, periods, acks, aslow, err, rd, strb);
    chk("b2b1_acks", acks, 1);
    chk("b2b1_rdata", rd, 16'h2468);
    chk("b2b1_busy_at_idle", BUSY, 1'b0);
    DATA_IN = 16'h9BDF;
    wait_edge(1'b1, "b2b_restart");
    chk("b2b_restart_busy", BUSY, 1'b1);
    run_cycle("b2b2", 1'b0, periods, acks, aslow, err, rd, strb);
    chk("b2b2_acks", acks, 1);
    chk("b2b2_rdata", rd, 16'h9BDF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/m68k_bus_sequencer.md
Name: m68k_bus_sequencer

Overview:
Runs one 68000 bus cycle, read or write, per host request on the PiStorm16 bus interface. It steps the S0–S7 bus states using the one-SYSCLK MCCLK_RISING/MCCLK_FALLING strobes and the DTACK_LATCH qualifier from the clock synchronizer. It drives AS/UDS/LDS/RW, address, FC and data-bus enable, and returns read data with a completion pulse. A wait-state timeout aborts cycles that never receive DTACK.

Parameters:
TIMEOUT_WAITS, 255, max MCCLK falling edges spent in S4 before abort (1..255)
ADDR_W, 23, address width (A23..A1)

Ports:
SYSCLK  in  1  FPGA system clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
MCCLK_RISING  in  1  one-SYSCLK strobe, 68000 clock rising edge
MCCLK_FALLING  in  1  one-SYSCLK strobe, 68000 clock falling edge
DTACK_LATCH  in  1  DTACK asserted and settled (data valid)
REQ  in  1  level request; held until ACK
REQ_WRITE  in  1  1=write, 0=read
REQ_ADDR  in  ADDR_W  word address
REQ_UDS  in  1  upper byte enable
REQ_LDS  in  1  lower byte enable
REQ_FC  in  3  function code
REQ_WDATA  in  16  write data
DATA_IN  in  16  sampled 68000 data bus
ACK  out  1  one-SYSCLK completion pulse
ERR  out  1  valid with ACK; 1 = timeout abort
RDATA  out  16  read data, valid from ACK until next ACK
BUSY  out  1  state != IDLE
AS_N  out  1  address strobe
UDS_N  out  1  upper data strobe
LDS_N  out  1  lower data strobe
RW  out  1  1=read
ADDR  out  ADDR_W  address bus
FC  out  3  function code bus
DATA_OUT  out  16  write data bus
DATA_OE  out  1  data bus drive enable

Behaviour:
- Reset: state=IDLE. AS_N=UDS_N=LDS_N=1, RW=1, DATA_OE=0, ACK=0, ERR=0, BUSY=0, ADDR=0, FC=0, DATA_OUT=0, RDATA=0, wait counter=0.
- Reset mid-cycle: the next cycle shows all strobes negated and DATA_OE=0. No ACK is issued for the aborted request.
- State advance uses only the strobes. Even states are entered on MCCLK_RISING, odd states on MCCLK_FALLING. With no strobe, state holds. If both strobes are high in one cycle (illegal), both are ignored.
- IDLE, on MCCLK_RISING with REQ=1 → S0. Latch the request fields. Set RW=~REQ_WRITE. REQ is sampled only here.
- S0 →(falling) S1: drive ADDR and FC.
- S1 →(rising) S2: AS_N=0. On a read, also UDS_N=~REQ_UDS and LDS_N=~REQ_LDS.
- S2 →(falling) S3: on a write, DATA_OUT=wdata and DATA_OE=1.
- S3 →(rising) S4: on a write, assert UDS_N/LDS_N per the enables. Clear the wait counter.
- S4, on MCCLK_FALLING:
  - DTACK_LATCH=1 → S5.
  - Otherwise the counter increments (8-bit, saturating). When it reaches TIMEOUT_WAITS, set the abort flag → S7.
- S5 →(rising) S6.
- S6 →(falling) S7: on a read, RDATA<=DATA_IN in the same cycle.
- At S7 entry: AS_N=UDS_N=LDS_N=1. Pulse ACK for one cycle. ERR=abort flag.
- S7 →(rising) IDLE: DATA_OE=0, RW=1, clear the abort flag.
- A new cycle can start no earlier than the rising edge after the return to IDLE. This gives a minimum of 4 MCCLK periods per cycle with zero wait states.
- The strobes are registered outputs and change in the SYSCLK cycle following the triggering strobe.
- A byte cycle with both enables 0 still runs the full cycle with no data strobe asserted.
- REQ dropped before ACK: undefined host error. The cycle still completes.

Decomposition:
- Shared package pistorm_bus_pkg holds:
  - the state enum (IDLE, S0–S7)
  - FC code constants (user/supervisor, data/program, CPU space)
  - DATA_W=16 and ADDR_W=23
- Natural sub-module: m68k_wait_counter. It provides a saturating wait-state count, clear/enable, and a terminal flag against TIMEOUT_WAITS.

Test Plan:
- Zero-wait read: REQ addr=0x000800, UDS=LDS=1, DTACK_LATCH high before the S4 falling edge, DATA_IN=0xBEEF → AS_N low from S2 to S7; ACK once with ERR=0, RDATA=0xBEEF; 4 MCCLK periods from the accepting rising edge to IDLE.
- Write, lower byte: REQ_WRITE=1, LDS=1, UDS=0, WDATA=0x12A5 → RW=0 from S0; DATA_OE=1 from S3; LDS_N low only from S4; UDS_N stays 1; DATA_OE=0 after S7→IDLE.
- 3 wait states: DTACK_LATCH rises after 3 S4 falling edges → cycle lengthened by 3 MCCLK periods; ACK with ERR=0.
- Timeout: TIMEOUT_WAITS=4, DTACK_LATCH never asserted → S7 after the 4th wait edge; ACK with ERR=1; strobes negated; RDATA unchanged.
- Reset in S4 of a read: RESET for 1 cycle → next cycle AS_N=UDS_N=LDS_N=1, BUSY=0, no ACK; a new REQ afterwards completes normally.
- Back-to-back REQ held high → the second cycle starts at the first MCCLK_RISING after IDLE; exactly one ACK per cycle.
